// File: rtl/hello_write_capture.sv
// hello_write_capture: collects a stream of letters into a frame buffer until
// the terminator arrives or the buffer fills, then drains the frame in order
// on a second port while reporting its length and a running frame count.
//
// Handshake: a transfer happens on a rising CLK edge where valid and ready
// are both high. The producer holds valid and data stable until that edge.
// Ready never depends on valid. Both ports follow this rule: in_* (this
// block is the consumer) and out_* (this block is the producer).
module hello_write_capture #(
  parameter int                DATA_W = 8,
  parameter int                DEPTH  = 12,
  parameter int                PTR_W  = 4,
  parameter logic [DATA_W-1:0] TERM   = 8'h0A
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [PTR_W-1:0]  frame_len,
  output logic              frame_done,
  output logic [7:0]        frame_count,
  output logic              dbg_state_o
);

  typedef enum logic {
    ST_CAPTURE = 1'b0,
    ST_DUMP    = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    frame_len_q, frame_len_d;
  logic [7:0]          frame_count_q, frame_count_d;
  logic                frame_done_q, frame_done_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic accept;
  logic send;
  logic close_frame;
  logic last_send;

  // A frame closes on the terminator or on the byte that fills the buffer;
  // when both hold on the same byte it still closes only once.
  assign accept      = in_valid & in_ready;
  assign send        = out_valid & out_ready;
  assign close_frame = accept & ((in_data == TERM) ||
                                 (wr_ptr_q == PTR_W'(DEPTH - 1)));
  assign last_send   = send & (rd_ptr_q == (frame_len_q - PTR_W'(1)));

  // State register; an asserted RST aborts any partial frame or drain at once.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_CAPTURE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: capture until the frame closes, drain until its last byte goes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CAPTURE: if (close_frame) state_d = ST_DUMP;
      ST_DUMP:    if (last_send)   state_d = ST_CAPTURE;
      default:    state_d = ST_CAPTURE;
    endcase
  end

  // Outputs: the two ports are never open at the same time, so a source
  // holding in_valid during a drain is simply back-pressured.
  always_comb begin
    in_ready    = (state_q == ST_CAPTURE);
    out_valid   = (state_q == ST_DUMP);
    out_data    = mem_q[rd_ptr_q];
    dbg_state_o = state_q;
    frame_len   = frame_len_q;
    frame_done  = frame_done_q;
    frame_count = frame_count_q;
  end

  // Pointer, length and counter next-state values.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    frame_len_d   = frame_len_q;
    frame_count_d = frame_count_q;
    frame_done_d  = last_send;
    if (accept) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (close_frame) begin
      frame_len_d = wr_ptr_q + PTR_W'(1);
      rd_ptr_d    = '0;
    end
    if (send) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (last_send) begin
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      frame_count_d = frame_count_q + 8'd1;
    end
  end

  // Pointer, length and counter registers; frame_len holds until the next close.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      frame_len_q   <= '0;
      frame_count_q <= '0;
      frame_done_q  <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      frame_len_q   <= frame_len_d;
      frame_count_q <= frame_count_d;
      frame_done_q  <= frame_done_d;
    end
  end

  // Frame storage; contents after reset are irrelevant, so it has no reset.
  always_ff @(posedge CLK) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_hello_write_capture.sv
// Testbench for hello_write_capture: sends letter frames, drains them and
// compares every drained byte, frame length and frame count with a model.
module tb_hello_write_capture;

  logic       CLK;
  logic       RST;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [3:0] frame_len;
  logic       frame_done;
  logic [7:0] frame_count;
  logic       dbg_state_o;

  int pass_cnt;
  int total_cnt;

  logic [7:0] tx_q[$];
  logic [7:0] exp_q[$];
  logic [3:0] exp_len_q[$];
  logic [7:0] exp_count;

  hello_write_capture dut (
    .CLK        (CLK),
    .RST        (RST),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .frame_len  (frame_len),
    .frame_done (frame_done),
    .frame_count(frame_count),
    .dbg_state_o(dbg_state_o)
  );

  // Clock and reset block
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic load_str(input string s);
    for (int i = 0; i < s.len(); i++) tx_q.push_back(s[i]);
  endtask

  // Driver: called on a negedge; sends every byte in tx_q, holding each one
  // until in_ready is high at a rising edge. Returns on the negedge after the
  // last accept.
  task automatic send_all();
    logic [7:0] b;
    logic       acc_now;
    logic       accepted;
    int         w;
    while (tx_q.size() > 0) begin
      b = tx_q.pop_front();
      in_valid = 1'b1;
      in_data  = b;
      exp_q.push_back(b);
      accepted = 1'b0;
      w = 0;
      while (!accepted && w < 500) begin
        acc_now = in_ready;
        @(negedge CLK);
        w++;
        accepted = acc_now;
      end
      if (!accepted) begin
        total_cnt++;
        $display("FAIL send_timeout: byte %h not accepted within %0d cycles", b, w);
      end
    end
    in_valid = 1'b0;
  endtask

  // Receiver/scoreboard: called on a negedge. mode 0 = always ready,
  // 1 = random ready, 2 = ready pattern 1,0,0,1 over valid cycles.
  // Stops after n_frames frame_done pulses, or after max_sends bytes if nonzero.
  task automatic drain(input int n_frames, input int mode, input int max_sends);
    int         done;
    int         sends;
    int         cyc;
    int         k;
    logic [3:0] pat;
    logic [7:0] exp_b;
    logic [3:0] exp_l;
    done = 0; sends = 0; cyc = 0; k = 0;
    pat = 4'b1001;
    while (done < n_frames && !(max_sends > 0 && sends >= max_sends) && cyc < 4000) begin
      if (frame_done === 1'b1) begin
        total_cnt++;
        if (exp_len_q.size() == 0) begin
          $display("FAIL frame_done_unexpected: got pulse, want none (frame_len %0d)", frame_len);
        end else begin
          exp_l = exp_len_q.pop_front();
          if (frame_len !== exp_l) $display("FAIL frame_len: got %0d want %0d", frame_len, exp_l);
          else pass_cnt++;
        end
        exp_count = exp_count + 8'd1;
        total_cnt++;
        if (frame_count !== exp_count) $display("FAIL frame_count: got %0d want %0d", frame_count, exp_count);
        else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL ready_after_done: got %b want 1", in_ready);
        else pass_cnt++;
        done++;
      end
      case (mode)
        1:       out_ready = 1'($urandom_range(0, 1));
        2:       out_ready = pat[k % 4];
        default: out_ready = 1'b1;
      endcase
      if (out_valid === 1'b1) begin
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL ready_during_dump: got %b want 0", in_ready);
        else pass_cnt++;
        total_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL out_unexpected: got %h want no byte", out_data);
        end else if (out_ready) begin
          exp_b = exp_q.pop_front();
          if (out_data !== exp_b) $display("FAIL out_data: got %h want %h", out_data, exp_b);
          else pass_cnt++;
          sends++;
        end else begin
          if (out_data !== exp_q[0]) $display("FAIL stall_hold: got %h want %h", out_data, exp_q[0]);
          else pass_cnt++;
        end
        k++;
      end
      @(negedge CLK);
      cyc++;
    end
    if (cyc >= 4000) begin
      total_cnt++;
      $display("FAIL drain_timeout: got %0d frames want %0d", done, n_frames);
    end
  endtask

  task automatic test_reset();
    #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else pass_cnt++;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else pass_cnt++;
    total_cnt++;
    if (frame_len !== 4'd0) $display("FAIL reset_frame_len: got %0d want 0", frame_len); else pass_cnt++;
    total_cnt++;
    if (frame_count !== 8'd0) $display("FAIL reset_frame_count: got %0d want 0", frame_count); else pass_cnt++;
    total_cnt++;
    if (frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b want 0", frame_done); else pass_cnt++;
    total_cnt++;
    if (dbg_state_o !== 1'b0) $display("FAIL reset_state: got %b want 0", dbg_state_o); else pass_cnt++;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    exp_count = 8'd0;
  endtask

  task automatic test_hello();
    out_ready = 1'b1;
    load_str("hello world\n");
    exp_len_q.push_back(4'd12);
    send_all();
    // first byte must be visible the cycle after the closing accept
    total_cnt++;
    if (in_ready !== 1'b0) $display("FAIL hello_in_ready: got %b want 0", in_ready); else pass_cnt++;
    total_cnt++;
    if (out_valid !== 1'b1) $display("FAIL hello_out_valid: got %b want 1", out_valid); else pass_cnt++;
    total_cnt++;
    if (out_data !== 8'h68) $display("FAIL hello_first_byte: got %h want 68", out_data); else pass_cnt++;
    total_cnt++;
    if (frame_len !== 4'd12) $display("FAIL hello_len_at_close: got %0d want 12", frame_len); else pass_cnt++;
    drain(1, 0, 0);
    total_cnt++;
    if (frame_count !== 8'd1) $display("FAIL hello_count: got %0d want 1", frame_count); else pass_cnt++;
  endtask

  task automatic test_hi();
    load_str("hi\n");
    exp_len_q.push_back(4'd3);
    fork
      send_all();
      drain(1, 0, 0);
    join
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL hi_ready_after: got %b want 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    // 12 letters fill the buffer; 'm' waits back-pressured and opens frame 2
    load_str("abcdefghijklmn\n");
    exp_len_q.push_back(4'd12);
    exp_len_q.push_back(4'd3);
    fork
      send_all();
      drain(2, 1, 0);
    join
  endtask

  task automatic test_stall();
    load_str("stall\n");
    exp_len_q.push_back(4'd6);
    fork
      send_all();
      drain(1, 2, 0);
    join
  endtask

  task automatic test_async_reset();
    // abort mid-capture
    load_str("abcde");
    out_ready = 1'b0;
    send_all();
    #3;
    RST = 1'b1;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL abort_cap_in_ready: got %b want 1", in_ready); else pass_cnt++;
    total_cnt++;
    if (frame_len !== 4'd0) $display("FAIL abort_cap_frame_len: got %0d want 0", frame_len); else pass_cnt++;
    total_cnt++;
    if (frame_count !== 8'd0) $display("FAIL abort_cap_count: got %0d want 0", frame_count); else pass_cnt++;
    @(negedge CLK);
    RST = 1'b0;
    exp_q.delete();
    exp_len_q.delete();
    exp_count = 8'd0;
    // abort mid-drain after two bytes
    load_str("vwxyz\n");
    exp_len_q.push_back(4'd6);
    send_all();
    drain(1, 0, 2);
    out_ready = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b1) $display("FAIL abort_drain_pre_valid: got %b want 1", out_valid); else pass_cnt++;
    #3;
    RST = 1'b1;
    #1;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL abort_drain_out_valid: got %b want 0", out_valid); else pass_cnt++;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL abort_drain_in_ready: got %b want 1", in_ready); else pass_cnt++;
    total_cnt++;
    if (frame_count !== 8'd0) $display("FAIL abort_drain_count: got %0d want 0", frame_count); else pass_cnt++;
    total_cnt++;
    if (frame_len !== 4'd0) $display("FAIL abort_drain_frame_len: got %0d want 0", frame_len); else pass_cnt++;
    @(negedge CLK);
    RST = 1'b0;
    exp_q.delete();
    exp_len_q.delete();
    exp_count = 8'd0;
  endtask

  task automatic test_count_wrap();
    for (int i = 0; i < 256; i++) begin
      tx_q.push_back(8'h0A);
      exp_len_q.push_back(4'd1);
    end
    fork
      send_all();
      drain(256, 0, 0);
    join
    total_cnt++;
    if (frame_count !== 8'd0) $display("FAIL wrap_count: got %0d want 0", frame_count); else pass_cnt++;
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL leftover_bytes: got %0d want 0", exp_q.size()); else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    exp_count = 8'd0;
    RST       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    test_reset();
    test_hello();
    test_hi();
    test_back_to_back();
    test_stall();
    test_async_reset();
    test_count_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/hello_write_capture.md
Name: hello_write_capture

Overview:
Receive-side counterpart of the letter generator. Accepts a stream of 8-bit letters over a valid/ready handshake and assembles them into a frame buffer. A frame closes on the terminator byte or when the buffer fills. The closed frame is then drained in order over a second valid/ready port to a simulation file writer ($fwrite side) or a downstream consumer, with frame length and frame count reported.

Parameters:
DATA_W, 8, letter width in bits
DEPTH, 12, frame buffer entries; maximum frame length
PTR_W, 4, pointer/length width; must satisfy 2^PTR_W > DEPTH
TERM, 8'h0A, terminator byte; stored as the last byte of the frame

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  asynchronous, active-high reset
in_valid  input  1  in_data is valid this cycle
in_data  input  DATA_W  incoming letter
in_ready  output  1  block can accept a letter
out_valid  output  1  out_data holds a stored frame byte
out_data  output  DATA_W  frame byte at the read pointer
out_ready  input  1  consumer accepts out_data
frame_len  output  PTR_W  length of the frame being or last drained, terminator included
frame_done  output  1  one-cycle pulse after the last byte of a frame is accepted
frame_count  output  8  frames completed; wraps 255 -> 0

Behaviour:
- Reset (RST=1, async): state=CAPTURE, wr_ptr=0, rd_ptr=0, frame_len=0, frame_count=0, frame_done=0, out_valid=0, in_ready=1. Buffer contents are don't-care.
- Accept event: in_valid & in_ready. Send event: out_valid & out_ready.
- State CAPTURE:
  - in_ready=1, out_valid=0.
  - On accept: mem[wr_ptr] <= in_data, wr_ptr <= wr_ptr+1.
  - If in_data==TERM or wr_ptr==DEPTH-1: next state DUMP, frame_len <= wr_ptr+1, rd_ptr <= 0.
  - in_valid with X data while in_ready=1 is a protocol error; no checking is required.
- State DUMP:
  - in_ready=0, out_valid=1, out_data=mem[rd_ptr] (combinational read of registered storage).
  - On send: rd_ptr <= rd_ptr+1.
  - If send and rd_ptr==frame_len-1: next state CAPTURE, wr_ptr <= 0, rd_ptr <= 0, frame_done <= 1 for the next cycle only, frame_count <= frame_count+1.
  - out_valid stays high and out_data stays stable while out_ready=0.
- Latency: the first byte is visible on out_data the cycle after the closing accept. Minimum turnaround is a frame of N bytes, then N drain cycles with out_ready held high, then capture resumes the next cycle.
- in_valid held during DUMP is back-pressured, not dropped. The source must hold its byte until in_ready=1.
- Zero-length frames cannot occur; the minimum frame is 1 byte (a lone TERM).
- The terminator arriving exactly at the DEPTH-th byte closes the frame once, with frame_len=DEPTH.
- frame_len holds its value through the following CAPTURE until the next frame closes.
- RST asserted mid-frame or mid-drain aborts immediately to reset values. A partial frame is discarded and frame_count is not incremented.

Test Plan:
- Reset, then send "hello world\n" (12 bytes, ending 0x0A) with out_ready=1 -> in_ready drops after the 12th byte; out_data sequence 68 65 6C 6C 6F 20 77 6F 72 6C 64 0A; frame_len=12; frame_done pulses once; frame_count=1.
- Send "hi\n" -> frame_len=3; bytes 68 69 0A drained; in_ready=1 on the cycle after frame_done.
- Send 14 bytes "abcdefghijklmn" with no TERM -> frame closes at byte 12 ('l') with frame_len=12; 'm' is held back-pressured (in_ready=0) and becomes the first byte of frame 2.
- During DUMP toggle out_ready 1,0,0,1 -> out_data holds steady during the stall; no byte skipped or duplicated; in_ready stays 0 throughout.
- Assert RST asynchronously after 5 bytes of a frame, then after 2 bytes drained of another -> all outputs return to reset values without waiting for a clock edge; frame_count is unchanged by the aborted frames (0 after reset).
- Drive 256 single-byte frames (0x0A) -> frame_count wraps to 0; each frame has frame_len=1.
